// File: rtl/fb_io_n_buf.sv
// Parametrised IO cell: a serial config chain picks one of NUM_IN channels and either
// registers it (mode 0) or queues it in a DEPTH-entry valid/ready FIFO (mode 1).
// Optional macro FB_IO_OCC_EN adds the occupancy output port.
module fb_io_n_buf #(
    parameter int size   = 32,
    parameter int NUM_IN = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     config_clk,
    input  logic                     config_reset,
    input  logic                     config_in,
    output logic                     config_out,
    input  logic [NUM_IN*size-1:0]   in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [size-1:0]          out0,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef FB_IO_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    localparam int SEL_W = $clog2(NUM_IN);
    localparam int CFG_W = SEL_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CFG_W-1:0] cfg;
    logic [SEL_W-1:0] sel;
    logic             mode;

    always_ff @(posedge config_clk or posedge config_reset) begin
        if (config_reset) cfg <= '0;
        else              cfg <= {config_in, cfg[CFG_W-1:1]};
    end

    assign config_out = cfg[0];
    assign sel        = cfg[SEL_W-1:0];
    assign mode       = cfg[SEL_W];

    // Handshake: a word moves on a rising clk edge only when valid and ready are both
    // high; in mode 1 ready depends on registered occupancy, never on out_ready.
    logic [size-1:0] sel_data;
    logic            sel_valid;
    logic            sel_ready;
    int              sel_idx;

    always_comb begin
        sel_idx   = (int'(sel) < NUM_IN) ? int'(sel) : 0;
        sel_data  = in_data[size-1:0];
        sel_valid = in_valid[0];
        in_ready  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (k == sel_idx) begin
                sel_data    = in_data[k*size +: size];
                sel_valid   = in_valid[k];
                in_ready[k] = sel_ready;
            end
        end
    end

    logic [size-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_valid;
    logic             push;
    logic             pop;
    logic [size-1:0]  leg_data;
    logic             leg_valid;

    assign fifo_valid = (count != '0);
    assign sel_ready  = mode ? (count != FULL_CNT) : 1'b1;
    assign push       = mode & sel_valid & sel_ready;
    assign pop        = mode & fifo_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (!mode) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sel_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leg_data  <= '0;
            leg_valid <= 1'b0;
        end else if (!mode) begin
            leg_data  <= sel_data;
            leg_valid <= sel_valid;
        end else begin
            leg_data  <= '0;
            leg_valid <= 1'b0;
        end
    end

    assign out_valid = mode ? fifo_valid : leg_valid;
    assign out0      = mode ? (fifo_valid ? mem[rd_ptr] : '0) : leg_data;

`ifdef FB_IO_OCC_EN
    assign occupancy = mode ? count : '0;
`endif

endmodule

// File: tb/tb_fb_io_n_buf.sv
// Directed self-checking bench for fb_io_n_buf (defaults: size=32, NUM_IN=4, DEPTH=4).
module tb_fb_io_n_buf;

    localparam int SIZE   = 32;
    localparam int NUM_IN = 4;
    localparam int DEPTH  = 4;

    logic                   clk;
    logic                   reset;
    logic                   config_clk;
    logic                   config_reset;
    logic                   config_in;
    logic                   config_out;
    logic [NUM_IN*SIZE-1:0] in_data;
    logic [NUM_IN-1:0]      in_valid;
    logic [NUM_IN-1:0]      in_ready;
    logic [SIZE-1:0]        out0;
    logic                   out_valid;
    logic                   out_ready;
`ifdef FB_IO_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

    fb_io_n_buf #(.size(SIZE), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .config_clk   (config_clk),
        .config_reset (config_reset),
        .config_in    (config_in),
        .config_out   (config_out),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out0         (out0),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef FB_IO_OCC_EN
        ,
        .occupancy    (occupancy)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    int              n_checks = 0;
    int              n_errors = 0;
    logic [SIZE-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        config_in  = b;
        #2 config_clk = 1'b1;
        #2 config_clk = 1'b0;
    endtask

    task automatic set_cfg(input logic mode, input logic [1:0] sel);
        logic [2:0] v;
        v = {mode, sel};
        for (int i = 0; i < 3; i++) shift_bit(v[i]);
    endtask

    task automatic dp_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic drive_ch(input int ch, input logic [SIZE-1:0] d);
        in_data[ch*SIZE +: SIZE] = d;
    endtask

    logic [SIZE-1:0] stream_d;

    initial begin
        reset        = 1'b1;
        config_reset = 1'b1;
        config_clk   = 1'b0;
        config_in    = 1'b0;
        in_data      = '0;
        in_valid     = '0;
        out_ready    = 1'b0;
        #3;
        check("rst_out0",      out0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_out",   config_out, 0);
        check("rst_in_ready",  in_ready, 4'b0001);
        #10;
        config_reset = 1'b0;
        reset        = 1'b0;

        // config shift 1,0,1 -> sel=1, mode=1
        shift_bit(1'b1);
        check("cfg_out_1", config_out, 0);
        shift_bit(1'b0);
        check("cfg_out_2", config_out, 0);
        shift_bit(1'b1);
        check("cfg_out_3", config_out, 1);
        check("cfg_ready_sel1", in_ready, 4'b0010);

        // legacy mode, sel=2
        set_cfg(1'b0, 2'd2);
        dp_reset();
        drive_ch(0, 32'h0000_0000);
        drive_ch(1, 32'h1111_1111);
        drive_ch(2, 32'hA5A5_A5A5);
        drive_ch(3, 32'h3333_3333);
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        check("leg_in_ready", in_ready, 4'b0100);
        step();
        check("leg_out0",  out0, 32'hA5A5_A5A5);
        check("leg_valid", out_valid, 1);
        drive_ch(2, 32'h5A5A_5A5A);
        in_valid = 4'b1011;
        step();
        check("leg_out0_2",  out0, 32'h5A5A_5A5A);
        check("leg_valid_2", out_valid, 0);
        in_valid = '0;

        // buffered mode, sel=1, fill to full with out_ready low
        set_cfg(1'b1, 2'd1);
        dp_reset();
        check("buf_empty_valid", out_valid, 0);
        check("buf_empty_out0",  out0, 0);
        in_valid = 4'b0010;
        for (int i = 1; i <= 4; i++) begin
            drive_ch(1, SIZE'(i * 32'h11));
            exp_q.push_back(SIZE'(i * 32'h11));
            step();
            check($sformatf("fill_ready_%0d", i), in_ready, (i == 4) ? 4'b0000 : 4'b0010);
        end
        check("full_valid", out_valid, 1);
`ifdef FB_IO_OCC_EN
        check("full_occ", occupancy, 4);
`endif

        // full + pop + 0x55 held valid: refused now, accepted next cycle
        drive_ch(1, 32'h55);
        exp_q.push_back(32'h55);
        out_ready = 1'b1;
        check("full_refuse", in_ready, 4'b0000);
        check("drain_0", out0, exp_q.pop_front());
        step();
        check("after_pop_ready", in_ready, 4'b0010);
        check("drain_1", out0, exp_q.pop_front());
        step();
        in_valid = '0;
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), out0, exp_q.pop_front());
            check($sformatf("drain_valid_%0d", i), out_valid, 1);
            step();
        end
        check("drain_q_left", exp_q.size(), 0);
        check("drained_valid", out_valid, 0);
        check("drained_out0",  out0, 0);

        // streaming 20 cycles, both sides always ready
        in_valid = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            stream_d = SIZE'(32'hC000_0000 + i * 32'h0101);
            drive_ch(1, stream_d);
            step();
            check($sformatf("stream_out0_%0d", i), out0, stream_d);
            check($sformatf("stream_valid_%0d", i), out_valid, 1);
`ifdef FB_IO_OCC_EN
            check($sformatf("stream_occ_%0d", i), occupancy, 1);
`endif
        end
        check("stream_ready", in_ready, 4'b0010);
        in_valid = '0;
        step();
        check("stream_end_valid", out_valid, 0);

        // async reset with 3 words buffered
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            drive_ch(1, SIZE'(32'hA1 + i));
            step();
        end
        in_valid = '0;
        check("pre_rst_out0", out0, 32'hA1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_out0",  out0, 0);
        #1 reset = 1'b0;
        drive_ch(1, 32'h77);
        in_valid = 4'b0010;
        check("post_rst_ready", in_ready, 4'b0010);
        step();
        in_valid  = '0;
        check("post_rst_out0",  out0, 32'h77);
        check("post_rst_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("post_rst_empty", out_valid, 0);
        check("post_rst_out0z", out0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
